// File: rtl/ahb_stream_loader_if.sv
// Byte-stream and AHB-Lite master signal bundle for the stream loader.
// The master modport is the loader side; the slave modport is the environment.
interface ahb_stream_loader_if;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, s_valid, s_data, s_last,
    input  HREADY, HRESP,
    output s_ready, HADDR, HTRANS, HWRITE,
    output HSIZE, HWDATA, busy, done, err
  );

  modport slave (
    output start, s_valid, s_data, s_last,
    output HREADY, HRESP,
    input  s_ready, HADDR, HTRANS, HWRITE,
    input  HSIZE, HWDATA, busy, done, err
  );
endinterface

// File: rtl/ahb_stream_loader.sv
// Packs a byte stream little-endian into words and writes them over
// AHB-Lite as single NONSEQ word transfers to incrementing addresses.
module ahb_stream_loader #(
  parameter int          AWIDTH    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic HCLK,
  input logic HRESET,
  ahb_stream_loader_if.master bus
);

  localparam int IW = AWIDTH - 2;

  typedef enum logic [1:0] {
    IDLE, COLLECT, ADDR, DATA
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic            last_q, last_d;
  logic            s_ready_q, s_ready_d;
  logic [1:0]      htrans_q, htrans_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     haddr_q, haddr_d;
  logic [31:0]     hwdata_q, hwdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  assign bus.s_ready = s_ready_q;
  assign bus.HTRANS  = htrans_q;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HSIZE   = 3'b010;
  assign bus.HADDR   = haddr_q;
  assign bus.HWDATA  = hwdata_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  // State and registered outputs; reset drops the bus to IDLE at once.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
      htrans_q  <= 2'b00;
      hwrite_q  <= 1'b0;
      haddr_q   <= BASE_ADDR;
      hwdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      last_q    <= last_d;
      s_ready_q <= s_ready_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      haddr_q   <= haddr_d;
      hwdata_q  <= hwdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next state and next registered outputs; collection and bus phases never overlap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    last_d    = last_q;
    s_ready_d = s_ready_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d     = '0;
          cnt_d     = '0;
          word_d    = '0;
          last_d    = 1'b0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          s_ready_d = 1'b1;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.s_valid && s_ready_q) begin
          // First byte of a word clears stale upper bytes.
          if (cnt_q == 2'd0) word_d = '0;
          word_d[{cnt_q, 3'b000} +: 8] = bus.s_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3 || bus.s_last) begin
            last_d    = bus.s_last;
            s_ready_d = 1'b0;
            htrans_d  = 2'b10;
            hwrite_d  = 1'b1;
            haddr_d   = BASE_ADDR + 32'({idx_q, 2'b00});
            state_d   = ADDR;
          end
        end
      end
      ADDR: begin
        if (bus.HREADY) begin
          htrans_d = 2'b00;
          hwrite_d = 1'b0;
          hwdata_d = word_q;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bus.HRESP) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.HREADY) begin
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
          if (last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            s_ready_d = 1'b1;
            state_d   = COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_stream_loader.sv
// Directed bench for ahb_stream_loader: bus monitor checked against an
// image-level model of packed words and wrapped addresses.
module tb_ahb_stream_loader;

  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h2000_0100;
  localparam int          NW   = 2 ** (AW - 2);

  typedef logic [7:0] bq_t[$];

  logic HCLK = 1'b0;
  logic HRESET;
  ahb_stream_loader_if bus();

  ahb_stream_loader #(.AWIDTH(AW), .BASE_ADDR(BASE)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_seen = 0;
  int wait_addr = 0;
  int wait_data = 0;
  bit err_mode = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input bq_t img, input int w);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 4; k++)
      if (4 * w + k < img.size()) d[8*k +: 8] = img[4*w+k];
    return d;
  endfunction

  function automatic logic [31:0] model_addr(input int w);
    return BASE + 32'((w % NW) * 4);
  endfunction

  task automatic model_push(input bq_t img);
    int nw;
    nw = (img.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      exp_a.push_back(model_addr(w));
      exp_d.push_back(model_word(img, w));
    end
  endtask

  // AHB slave: programmable wait states and two-cycle ERROR response.
  initial begin
    bit in_data;
    int acnt, dcnt, ecnt;
    in_data = 0; acnt = 0; dcnt = 0; ecnt = 0;
    bus.HREADY = 1'b1;
    bus.HRESP = 1'b0;
    forever begin
      @(posedge HCLK); #1;
      if (HRESET) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        in_data = 0; acnt = 0; dcnt = 0; ecnt = 0;
      end else if (in_data) begin
        if (err_mode) begin
          if (ecnt == 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b1; ecnt = 1;
          end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b1; ecnt = 0;
          end
        end else if (dcnt < wait_data) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b0; dcnt++;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = 1'b0; dcnt = 0;
        end
        in_data = !bus.HREADY;
      end else begin
        bus.HRESP = 1'b0;
        if (bus.HTRANS == 2'b10) begin
          if (acnt < wait_addr) begin
            bus.HREADY = 1'b0; acnt++;
          end else begin
            bus.HREADY = 1'b1; acnt = 0; in_data = 1;
          end
        end else begin
          bus.HREADY = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, bus writes and status against the model.
  initial begin
    bit dpend, p_dpend, pv;
    logic [1:0]  p_htrans;
    logic [31:0] p_haddr, p_hwdata, wa;
    logic p_hready, p_busy, p_done;
    dpend = 0; p_dpend = 0; pv = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dpend = 0; pv = 0;
      end else begin
        if (pv && p_htrans == 2'b10 && !p_hready)
          check("addr_hold", {bus.HTRANS, bus.HADDR}, {2'b10, p_haddr});
        if (pv && dpend && p_dpend && !p_hready)
          check("wdata_hold", bus.HWDATA, p_hwdata);
        p_dpend = dpend;
        if (dpend) begin
          check("dphase_idle", {bus.HTRANS, bus.s_ready}, 3'b000);
          if (bus.HRESP) begin
            err_seen++; dpend = 0;
          end else if (bus.HREADY) begin
            dpend = 0;
            if (exp_a.size() == 0) begin
              check("unexpected_write", wa, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              check("wr_addr", wa, exp_a.pop_front());
              check("wr_data", bus.HWDATA, exp_d.pop_front());
            end
          end
        end
        if (bus.HTRANS == 2'b10) begin
          check("aphase", {bus.s_ready, bus.HWRITE, bus.HSIZE}, 5'b01010);
          if (bus.HREADY) begin
            dpend = 1; wa = bus.HADDR;
          end
        end
        if (!bus.busy) check("idle_ready", bus.s_ready, 0);
        if (bus.done) begin
          done_cnt++;
          check("done_busy", {bus.busy, p_busy, p_done}, 3'b010);
        end
        p_htrans = bus.HTRANS; p_haddr = bus.HADDR;
        p_hwdata = bus.HWDATA; p_hready = bus.HREADY;
        p_busy = bus.busy; p_done = bus.done; pv = 1;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    bus.s_valid = 1'b1; bus.s_data = b; bus.s_last = last;
    forever begin
      @(negedge HCLK);
      if (bus.s_ready) break;
      t++;
      if (t > 50) begin
        check("send_timeout", t, 0);
        break;
      end
    end
    @(posedge HCLK); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic send_img(input bq_t img, input bit last);
    for (int i = 0; i < img.size(); i++)
      send(img[i], last && (i == img.size() - 1));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge HCLK); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge HCLK);
      if (!bus.busy) break;
      t++;
      if (t > 300) begin
        check("idle_timeout", t, 0);
        break;
      end
    end
    @(posedge HCLK); #1;
  endtask

  initial begin
    bq_t img;
    int d0, t;
    HRESET = 1'b1;
    bus.start = 1'b0; bus.s_valid = 1'b0;
    bus.s_data = '0; bus.s_last = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_bus", {bus.HTRANS, bus.HWRITE, bus.HSIZE}, 6'b00_0_010);
    check("rst_haddr", bus.HADDR, BASE);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_status", {bus.s_ready, bus.busy, bus.done, bus.err}, 0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    check("model_w1", model_word(img, 1), 32'h0807_0605);
    img = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    check("model_partial", model_word(img, 1), 32'h0000_1615);
    check("model_wrap", model_addr(4), 32'h2000_0100);

    // Two full words
    d0 = done_cnt;
    exp_a.push_back(BASE);     exp_d.push_back(32'h0403_0201);
    exp_a.push_back(BASE + 4); exp_d.push_back(32'h0807_0605);
    do_start();
    check("busy_after_start", bus.busy, 1);
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_img(img, 1);
    wait_idle();
    check("t1_done", done_cnt - d0, 1);
    check("t1_drained", exp_a.size(), 0);

    // Partial last word
    d0 = done_cnt;
    exp_a.push_back(BASE);     exp_d.push_back(32'h1413_1211);
    exp_a.push_back(BASE + 4); exp_d.push_back(32'h0000_1615);
    do_start();
    img = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_img(img, 1);
    wait_idle();
    check("t2_done", done_cnt - d0, 1);
    check("t2_drained", exp_a.size(), 0);

    // Wait states in both phases
    d0 = done_cnt;
    wait_addr = 3; wait_data = 2;
    img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
    model_push(img);
    do_start();
    send_img(img, 1);
    wait_idle();
    wait_addr = 0; wait_data = 0;
    check("t3_done", done_cnt - d0, 1);
    check("t3_drained", exp_a.size(), 0);

    // ERROR response on first word
    d0 = done_cnt; t = err_seen;
    err_mode = 1;
    do_start();
    img = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_img(img, 0);
    wait_idle();
    err_mode = 0;
    check("t4_err", {bus.err, bus.busy}, 2'b10);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_err_seen", err_seen - t, 1);
    img = '{8'hAA};
    model_push(img);
    do_start();
    check("t4_err_clr", bus.err, 0);
    send_img(img, 1);
    wait_idle();
    check("t4_restart", {exp_a.size(), bus.err}, 0);

    // Address wrap with a 16-byte window
    d0 = done_cnt;
    img.delete();
    for (int i = 1; i <= 20; i++) img.push_back(8'(8'h40 + i));
    model_push(img);
    do_start();
    send_img(img, 1);
    wait_idle();
    check("t5_done", done_cnt - d0, 1);
    check("t5_drained", exp_a.size(), 0);

    // start while busy is ignored
    d0 = done_cnt;
    img = '{8'h21, 8'h22, 8'h23, 8'h24};
    model_push(img);
    do_start();
    send(8'h21, 0);
    send(8'h22, 0);
    do_start();
    send(8'h23, 0);
    send(8'h24, 1);
    wait_idle();
    check("t6_done", done_cnt - d0, 1);
    check("t6_drained", exp_a.size(), 0);

    // Reset during address phase
    wait_addr = 20;
    do_start();
    img = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_img(img, 1);
    t = 0;
    while (bus.HTRANS != 2'b10 && t < 20) begin
      @(negedge HCLK); t++;
    end
    check("t6_in_addr", bus.HTRANS, 2'b10);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    check("t6_rst_bus", {bus.HTRANS, bus.HWRITE, bus.busy}, 0);
    repeat (2) @(posedge HCLK);
    #1;
    wait_addr = 0;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    d0 = done_cnt;
    img = '{8'h55};
    model_push(img);
    do_start();
    send_img(img, 1);
    wait_idle();
    check("t6_recover", done_cnt - d0, 1);
    check("final_drained", exp_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
